latch_bank: RTL and testbench
=============================

Name: latch_bank

Overview:
- Bank of three independent, clock-sampled D-latch cells sharing one data input `D`.
- Each cell has its own enable polarity and clear/preset options:
  - Cell 1: plain, enable active-high.
  - Cell 2: enable active-low, synchronous clear active-high.
  - Cell 3: enable active-high, clear and preset both active-low.
- Used as a small, configurable holding-register block.
- All state updates on the rising clock edge, which keeps the design free of true level-sensitive latches.

Parameters:
- None.

Ports:
- clk   input  1  system clock; all state updates on rising edge
- rst   input  1  asynchronous active-high reset
- D     input  1  shared data input to all three cells
- ena1  input  1  cell 1 enable, active-high (1 = transparent/track, 0 = hold)
- ena2  input  1  cell 2 enable, active-low (0 = track, 1 = hold)
- clr2  input  1  cell 2 clear, active-high
- ena3  input  1  cell 3 enable, active-high
- clr3  input  1  cell 3 clear, active-low
- pre3  input  1  cell 3 preset, active-low
- Q1    output 1  cell 1 state
- Q2    output 1  cell 2 state
- Q3    output 1  cell 3 state

Behaviour:
- One clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset:
  - `rst`=1 forces Q1=Q2=Q3=0 immediately, independent of `clk`, and holds them at 0 while asserted.
  - On deassertion, all cells resume normal operation at the next rising `clk`.
  - Reset overrides every other input.
- Outputs are driven directly from state flops; no combinational path from inputs to Q.
- Latency: an input change sampled at rising edge N appears on Q after edge N, i.e. one-cycle latency.
- Cell 1, evaluated each rising edge:
  - ena1=1: Q1 <= D.
  - ena1=0: Q1 holds.
- Cell 2, evaluated each rising edge, in priority order:
  - clr2=1: Q2 <= 0.
  - else ena2=0: Q2 <= D.
  - else: Q2 holds.
  - Clear is synchronous. Once clr2 returns to 0 with ena2=0, Q2 tracks D again on the next edge.
- Cell 3, evaluated each rising edge, in priority order:
  - clr3=0: Q3 <= 0.
  - else pre3=0: Q3 <= 1.
  - else ena3=1: Q3 <= D.
  - else: Q3 holds.
  - Clear and preset are synchronous.
  - Simultaneous clr3=0 and pre3=0: clear wins, Q3=0.
  - When clr3 and pre3 both return to 1 with ena3=1, Q3 tracks D on the next edge.
- Cells are fully independent: a control input of one cell never affects another cell.
- Enable inactive means the last stored value is held indefinitely, regardless of D activity.
- X/unknown control inputs: no requirement. The bench must drive all controls to known values after reset.

Test Plan:
- Reset and cell 1:
  - Stimulus: rst=1 mid-operation with Q1=Q2=Q3=1 (no clk edge).
  - Required: all Q=0 immediately.
  - Then rst=0, ena1=1, D sequence 0,1,0, one value per cycle -> Q1 follows 0,1,0 with one-cycle lag.
- Cell 1 hold:
  - Stimulus: Q1=0, ena1=0, D=1 for 3 cycles.
  - Required: Q1 stays 0.
  - Then ena1=1 -> Q1=1 after next edge.
- Cell 2 enable and clear:
  - Stimulus: ena2=0, clr2=0, D=0,1,0 -> Q2 follows.
  - ena2=1, D=1 -> Q2 holds 0.
  - ena2=0 -> Q2=1.
  - clr2=1 -> Q2=0.
  - clr2=0 with D=1 -> Q2=1.
- Cell 3 enable, clear, preset:
  - Stimulus: clr3=pre3=1, ena3=1, D=0,1,0 -> Q3 follows.
  - ena3=0, D=1 -> Q3 holds 0.
  - ena3=1 -> Q3=1.
  - clr3=0 -> Q3=0.
  - clr3=1 -> Q3=1.
  - D=0, pre3=0 -> Q3=1.
  - pre3=1 -> Q3=0.
- Cell 3 priority:
  - Stimulus: D=1, ena3=1, clr3=0 and pre3=0 together.
  - Required: Q3=0.
  - Then both released to 1 -> Q3=1.
- Independence:
  - Stimulus: toggle clr2, clr3, pre3, ena2, ena3 while ena1=0.
  - Required: Q1 unchanged.
  - Likewise, cell 1 and cell 3 activity leaves Q2 unchanged.

Source files
------------

// File: rtl/latch_bank_if.sv
// latch_bank_if: shared data, per-cell controls and cell outputs of the latch bank
interface latch_bank_if;
  logic D;
  logic ena1;
  logic ena2;
  logic clr2;
  logic ena3;
  logic clr3;
  logic pre3;
  logic Q1;
  logic Q2;
  logic Q3;
  modport master (output D, ena1, ena2, clr2, ena3, clr3, pre3, input Q1, Q2, Q3);
  modport slave (input D, ena1, ena2, clr2, ena3, clr3, pre3, output Q1, Q2, Q3);
endinterface

// File: rtl/latch_bank.sv
// latch_bank: three clock-sampled latch cells sharing one data input
module latch_bank (
  input logic clk,
  input logic rst,
  latch_bank_if.slave io_lb
);
  logic r_q1;
  logic r_q2;
  logic r_q3;
  // cell 1: track D while enabled, otherwise hold
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q1 <= 1'b0;
    else if (io_lb.ena1) r_q1 <= io_lb.D;
  // cell 2: clear beats the active-low enable
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q2 <= 1'b0;
    else if (io_lb.clr2) r_q2 <= 1'b0;
    else if (!io_lb.ena2) r_q2 <= io_lb.D;
  // cell 3: active-low clear beats active-low preset, both beat the enable
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q3 <= 1'b0;
    else if (!io_lb.clr3) r_q3 <= 1'b0;
    else if (!io_lb.pre3) r_q3 <= 1'b1;
    else if (io_lb.ena3) r_q3 <= io_lb.D;
  assign io_lb.Q1 = r_q1;
  assign io_lb.Q2 = r_q2;
  assign io_lb.Q3 = r_q3;
endmodule

// File: tb/tb_latch_bank.sv
// tb_latch_bank: directed checks of reset, each cell, cell 3 priority and cell independence
module tb_latch_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  latch_bank_if lb ();
  latch_bank dut (.clk(clk), .rst(rst), .io_lb(lb));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic chk3(input string tag, input logic e1, input logic e2, input logic e3);
    chk({tag, "_q1"}, lb.Q1, e1);
    chk({tag, "_q2"}, lb.Q2, e2);
    chk({tag, "_q3"}, lb.Q3, e3);
  endtask
  initial begin
    lb.D = 1'b0;
    lb.ena1 = 1'b0;
    lb.ena2 = 1'b1;
    lb.clr2 = 1'b0;
    lb.ena3 = 1'b0;
    lb.clr3 = 1'b1;
    lb.pre3 = 1'b1;
    step();
    chk3("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    lb.D = 1'b1;
    lb.ena1 = 1'b1;
    lb.ena2 = 1'b0;
    lb.ena3 = 1'b1;
    step();
    chk3("all_set", 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk3("async_rst", 1'b0, 1'b0, 1'b0);
    step();
    chk3("rst_held", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    lb.ena2 = 1'b1;
    lb.ena3 = 1'b0;
    lb.D = 1'b0;
    step();
    chk("c1_d0", lb.Q1, 1'b0);
    lb.D = 1'b1;
    step();
    chk("c1_d1", lb.Q1, 1'b1);
    lb.D = 1'b0;
    step();
    chk("c1_d0b", lb.Q1, 1'b0);
    lb.ena1 = 1'b0;
    lb.D = 1'b1;
    step();
    chk("c1_hold1", lb.Q1, 1'b0);
    step();
    chk("c1_hold2", lb.Q1, 1'b0);
    step();
    chk3("c1_hold3", 1'b0, 1'b0, 1'b0);
    lb.ena1 = 1'b1;
    step();
    chk("c1_reen", lb.Q1, 1'b1);
    lb.ena1 = 1'b0;
    lb.ena2 = 1'b0;
    lb.D = 1'b0;
    step();
    chk("c2_d0", lb.Q2, 1'b0);
    lb.D = 1'b1;
    step();
    chk("c2_d1", lb.Q2, 1'b1);
    lb.D = 1'b0;
    step();
    chk("c2_d0b", lb.Q2, 1'b0);
    lb.ena2 = 1'b1;
    lb.D = 1'b1;
    step();
    chk("c2_hold", lb.Q2, 1'b0);
    lb.ena2 = 1'b0;
    step();
    chk("c2_reen", lb.Q2, 1'b1);
    lb.clr2 = 1'b1;
    step();
    chk("c2_clr", lb.Q2, 1'b0);
    lb.clr2 = 1'b0;
    step();
    chk3("c2_unclr", 1'b1, 1'b1, 1'b0);
    lb.ena2 = 1'b1;
    lb.ena3 = 1'b1;
    lb.D = 1'b0;
    step();
    chk("c3_d0", lb.Q3, 1'b0);
    lb.D = 1'b1;
    step();
    chk("c3_d1", lb.Q3, 1'b1);
    lb.D = 1'b0;
    step();
    chk("c3_d0b", lb.Q3, 1'b0);
    lb.ena3 = 1'b0;
    lb.D = 1'b1;
    step();
    chk("c3_hold", lb.Q3, 1'b0);
    lb.ena3 = 1'b1;
    step();
    chk("c3_reen", lb.Q3, 1'b1);
    lb.clr3 = 1'b0;
    step();
    chk("c3_clr", lb.Q3, 1'b0);
    lb.clr3 = 1'b1;
    step();
    chk("c3_unclr", lb.Q3, 1'b1);
    lb.D = 1'b0;
    lb.pre3 = 1'b0;
    step();
    chk("c3_pre", lb.Q3, 1'b1);
    lb.pre3 = 1'b1;
    step();
    chk("c3_unpre", lb.Q3, 1'b0);
    lb.D = 1'b1;
    lb.clr3 = 1'b0;
    lb.pre3 = 1'b0;
    step();
    chk("c3_prio", lb.Q3, 1'b0);
    lb.clr3 = 1'b1;
    lb.pre3 = 1'b1;
    step();
    chk3("c3_release", 1'b1, 1'b1, 1'b1);
    lb.D = 1'b0;
    lb.clr2 = 1'b1;
    lb.ena2 = 1'b0;
    lb.clr3 = 1'b0;
    lb.pre3 = 1'b0;
    lb.ena3 = 1'b1;
    step();
    chk3("ind_q1", 1'b1, 1'b0, 1'b0);
    lb.clr2 = 1'b0;
    lb.ena2 = 1'b1;
    lb.ena3 = 1'b0;
    lb.clr3 = 1'b1;
    step();
    chk3("ind_q1b", 1'b1, 1'b0, 1'b1);
    lb.D = 1'b1;
    lb.ena1 = 1'b1;
    lb.ena3 = 1'b1;
    lb.pre3 = 1'b1;
    step();
    chk3("ind_q2", 1'b1, 1'b0, 1'b1);
    lb.D = 1'b0;
    lb.pre3 = 1'b0;
    step();
    chk3("ind_q2b", 1'b0, 1'b0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
